// File: rtl/sub_word_engine.sv
// sub_word_engine: multi-cycle AES SubWord unit for the key-expansion path.
// Substitutes each byte of a BYTES-wide word through the AES encryption S-box.
// It handles LANES bytes per cycle, so one word takes K = BYTES/LANES cycles.
// Control uses a start/busy/done handshake.
//
// Ports:
//   clk       system clock, rising edge
//   resetn    asynchronous reset, active low
//   start     request pulse, accepted only while busy==0
//   in_word   word to substitute, byte i = bits [8i+7:8i]
//   rot       RotWord request sampled with start (only with SUB_WORD_ROT_EN)
//   busy      high from the edge after an accepted start until done
//   done      one-cycle pulse, out_word valid from this cycle on
//   out_word  substituted word, held until the next completion
//
// Optional feature: define SUB_WORD_ROT_EN to add the rot port and the
// rotate-left-by-one-byte on capture.

module sub_word_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module sub_word_engine #(
  parameter int BYTES = 4,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [8*BYTES-1:0] in_word,
`ifdef SUB_WORD_ROT_EN
  input  logic               rot,
`endif
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] out_word
);
  localparam int W  = 8 * BYTES;
  localparam int K  = BYTES / LANES;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  // Word viewed as K groups of LANES bytes; group g feeds the lanes on cycle g.
  typedef logic [K-1:0][LANES-1:0][7:0] word_t;
  typedef enum logic {IDLE, SUB} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          grp;
  word_t                  cap, mid, fin, capture;
  logic [LANES-1:0][7:0]  sel, sub;
  logic                   accept, last;

  // Capture value, optionally RotWord'ed (top byte wraps to byte 0).
`ifdef SUB_WORD_ROT_EN
  logic [2*W-1:0] dbl;
  assign dbl = {in_word, in_word};
  always_comb begin
    capture = in_word;
    if (rot) capture = dbl[2*W-9 -: W];
  end
`else
  assign capture = in_word;
`endif

  // Group select; compare-based so K==1 needs no zero-width index.
  always_comb begin
    sel = '0;
    for (int j = 0; j < K; j++)
      if (grp == CW'(j)) sel = cap[j];
  end

  sub_word_sbox u_sbox [LANES-1:0] (
    .in_byte  (sel),
    .out_byte (sub)
  );

  // Completed word: earlier groups from mid, final group straight from lanes.
  always_comb begin
    fin        = mid;
    fin[K-1]   = sub;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = SUB;
      end
      SUB: if (grp == LAST) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_word <= '0;
      grp      <= '0;
      cap      <= '0;
      mid      <= '0;
    end else begin
      state <= state_nxt;
      done  <= last;
      if (accept) begin
        cap  <= capture;
        grp  <= '0;
        busy <= 1'b1;
      end
      if (state == SUB) begin
        for (int j = 0; j < K; j++)
          if (grp == CW'(j)) mid[j] <= sub;
        if (!last) grp <= grp + CW'(1);
      end
      if (last) begin
        out_word <= fin;
        busy     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sub_word_engine.sv
module tb_sub_word_engine;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] word_a = '0, word_b = '0;
`ifdef SUB_WORD_ROT_EN
  logic        rot = 1'b0;
`endif
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] out_a, out_b;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];

  always #5 clk = ~clk;

  sub_word_engine #(.BYTES(4), .LANES(1)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .in_word(word_a),
`ifdef SUB_WORD_ROT_EN
    .rot(rot),
`endif
    .busy(busy_a), .done(done_a), .out_word(out_a)
  );

  sub_word_engine #(.BYTES(4), .LANES(4)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .in_word(word_b),
`ifdef SUB_WORD_ROT_EN
    .rot(rot),
`endif
    .busy(busy_b), .done(done_b), .out_word(out_b)
  );

  // Stimulus helper: counts edges after acceptance until done (bounded).
  task automatic wait_done_a(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done_a && lat < 20) begin
      if (busy_a) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_a = ~start_a; start_b = ~start_b;
      word_a = 32'h53ff0100; word_b = 32'h53ff0100;
      exp = '0;
      vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
      vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done_a); end
      vectors++; if (out_a !== exp) begin miscompares++; $display("FAIL reset_out: got %h expected %h", out_a, exp); end
      vectors++; if (out_b !== exp || busy_b !== 1'b0) begin miscompares++; $display("FAIL reset_lanes4: got out %h busy %b expected %h busy 0", out_b, busy_b, exp); end
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default();
    logic [31:0] ins  [2] = '{32'h53ff0100, 32'h00000001};
    logic [31:0] exps [2] = '{32'hed167c63, 32'h6363637c};
    logic [31:0] prev, exp;
    int lat, bc;
    prev = 32'h0;
    for (int v = 0; v < 2; v++) begin
      word_a = ins[v]; start_a = 1'b1; sb_a.push_back(exps[v]);
      @(negedge clk);
      start_a = 1'b0; word_a = 32'hdeadbeef;
      vectors++; if (out_a !== prev) begin miscompares++; $display("FAIL default_hold: got %h expected %h", out_a, prev); end
      wait_done_a(lat, bc);
      vectors++; if (lat != 4) begin miscompares++; $display("FAIL default_latency: got %0d expected 4", lat); end
      vectors++; if (bc != 4) begin miscompares++; $display("FAIL default_busy_cycles: got %0d expected 4", bc); end
      vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL default_busy_at_done: got %b expected 0", busy_a); end
      exp = (sb_a.size() > 0) ? sb_a.pop_front() : 32'hxxxxxxxx;
      vectors++; if (out_a !== exp) begin miscompares++; $display("FAIL default_result: got %h expected %h", out_a, exp); end
      @(negedge clk);
      vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL default_done_pulse: got %b expected 0", done_a); end
      vectors++; if (out_a !== exp) begin miscompares++; $display("FAIL default_out_held: got %h expected %h", out_a, exp); end
      prev = exp;
    end
  endtask

  task automatic test_lanes4();
    logic [31:0] ins  [2] = '{32'h00000000, 32'h53ff0100};
    logic [31:0] exps [2] = '{32'h63636363, 32'hed167c63};
    logic [31:0] exp;
    int lat;
    for (int v = 0; v < 2; v++) begin
      word_b = ins[v]; start_b = 1'b1; sb_b.push_back(exps[v]);
      @(negedge clk);
      start_b = 1'b0; word_b = 32'hffffffff;
      lat = 0;
      while (!done_b && lat < 20) begin @(negedge clk); lat++; end
      vectors++; if (lat != 1) begin miscompares++; $display("FAIL lanes4_latency: got %0d expected 1", lat); end
      exp = (sb_b.size() > 0) ? sb_b.pop_front() : 32'hxxxxxxxx;
      vectors++; if (out_b !== exp) begin miscompares++; $display("FAIL lanes4_result: got %h expected %h", out_b, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int lat, bc, extra;
    word_a = 32'h00000000; start_a = 1'b1; sb_a.push_back(32'h63636363);
    @(negedge clk);
    // Busy now: this pulse must be ignored.
    word_a = 32'hffffffff; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; word_a = 32'h0;
    lat = 1;
    while (!done_a && lat < 20) begin @(negedge clk); lat++; end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL b2b_ignored_latency: got %0d expected 4", lat); end
    exp = (sb_a.size() > 0) ? sb_a.pop_front() : 32'hxxxxxxxx;
    vectors++; if (out_a !== exp) begin miscompares++; $display("FAIL b2b_ignored_result: got %h expected %h", out_a, exp); end
    // Start in the done cycle.
    word_a = 32'h01010101; start_a = 1'b1; sb_a.push_back(32'h7c7c7c7c);
    @(negedge clk);
    start_a = 1'b0; word_a = 32'h0;
    vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_busy: got %b expected 1", busy_a); end
    wait_done_a(lat, bc);
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    exp = (sb_a.size() > 0) ? sb_a.pop_front() : 32'hxxxxxxxx;
    vectors++; if (out_a !== exp) begin miscompares++; $display("FAIL b2b_result: got %h expected %h", out_a, exp); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done_a) extra++; end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL b2b_spurious_done: got %0d expected 0", extra); end
  endtask

  task automatic test_abort();
    logic [31:0] exp;
    int lat, bc, extra;
    word_a = 32'h53ff0100; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
    vectors++; if (out_a !== 32'h0) begin miscompares++; $display("FAIL abort_out: got %h expected 00000000", out_a); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done_a) extra++; end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected 0", extra); end
    vectors++; if (out_a !== 32'h0) begin miscompares++; $display("FAIL abort_out_after: got %h expected 00000000", out_a); end
    word_a = 32'h53ff0100; start_a = 1'b1; sb_a.push_back(32'hed167c63);
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(lat, bc);
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL abort_restart_latency: got %0d expected 4", lat); end
    exp = (sb_a.size() > 0) ? sb_a.pop_front() : 32'hxxxxxxxx;
    vectors++; if (out_a !== exp) begin miscompares++; $display("FAIL abort_restart_result: got %h expected %h", out_a, exp); end
    @(negedge clk);
  endtask

`ifdef SUB_WORD_ROT_EN
  task automatic test_rot();
    logic        rots [2] = '{1'b1, 1'b0};
    logic [31:0] exps [2] = '{32'h167c63ed, 32'hed167c63};
    logic [31:0] exp;
    int lat, bc;
    for (int v = 0; v < 2; v++) begin
      word_a = 32'h53ff0100; rot = rots[v]; start_a = 1'b1; sb_a.push_back(exps[v]);
      @(negedge clk);
      start_a = 1'b0; rot = ~rots[v];
      wait_done_a(lat, bc);
      vectors++; if (lat != 4) begin miscompares++; $display("FAIL rot_latency: got %0d expected 4", lat); end
      exp = (sb_a.size() > 0) ? sb_a.pop_front() : 32'hxxxxxxxx;
      vectors++; if (out_a !== exp) begin miscompares++; $display("FAIL rot_result: got %h expected %h", out_a, exp); end
      @(negedge clk);
    end
    rot = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_lanes4();
    test_back_to_back();
    test_abort();
`ifdef SUB_WORD_ROT_EN
    test_rot();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
